logic_unit_serial: RTL and testbench
====================================

// Module: logic_unit_serial
// PURPOSE
//  Multi-cycle bitwise logic unit (AND/OR/XOR/XNOR) for the pipeline's long-latency execute path.
//  Operates on CHUNK_WIDTH bits per cycle to trade latency for area.
//  Responder side of a valid/ready request/response handshake: execute stage issues SrcA/SrcB/Operation, unit returns Rd.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width; must be a multiple of CHUNK_WIDTH (1 allowed)
//  OPCODE_LENGTH  4   width of Operation
//  CHUNK_WIDTH    8   bits processed per RUN cycle; N = DATA_WIDTH/CHUNK_WIDTH chunks
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-low reset
//  in_valid   in   1              request valid
//  in_ready   out  1              unit can accept request
//  Operation  in   OPCODE_LENGTH  4'b0000 AND, 4'b0001 OR, 4'b0011 XOR, 4'b0100 XNOR
//  SrcA       in   DATA_WIDTH     operand A
//  SrcB       in   DATA_WIDTH     operand B
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
//  Rd         out  DATA_WIDTH     result; stable while out_valid=1
//  illegal_op out  1              qualified by out_valid; request opcode was not one of the four above
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  Reset (reset=0 at a clk edge): state=IDLE; in_ready=1 from next cycle; out_valid=0, Rd=0, illegal_op=0, busy=0, chunk counter=0.
//  Reset mid-operation discards the request in flight; no response is ever produced for it.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: in_ready=1. Edge with in_valid=1 latches SrcA, SrcB, Operation; clears Rd, cnt=0; -> RUN.
//   RUN: in_ready=0. Each edge writes Rd[cnt*CW +: CW] = op(A_chunk, B_chunk); cnt++.
//        Edge with cnt==N-1 -> DONE.
//   DONE: out_valid=1. Edge with out_ready=1 -> IDLE; Rd holds its last value; out_valid drops.
//  Latency: out_valid first seen high N+1 edges after the accepting edge (N edges in RUN plus the accepting edge).
//  Throughput: one request per N+2 cycles. No accept in DONE, even if out_ready=1 in the same cycle.
//  Illegal opcode: full RUN sequence executes; Rd=0; illegal_op=1 while out_valid=1.
//  Inputs are ignored while in_ready=0. out_ready is ignored while out_valid=0.
//  Backpressure: DONE holds indefinitely; Rd and illegal_op remain unchanged.
//  DATA_WIDTH==CHUNK_WIDTH (N=1): RUN lasts one cycle; counter width is max(1, $clog2(N)).
//  No combinational path from any input to any output.
// CONFIGURATION
//  `LOGIC_UNIT_ZERO_FLAG_EN defined:
//   adds port Zero (out, 1). A sticky nonzero flag is cleared on accept and ORed with each chunk result during RUN.
//   Zero = ~nonzero, qualified by out_valid. Reset value 0. Zero=1 for an illegal opcode.
//  Not defined: no Zero port, no flag register; all other behaviour is identical.
// TESTING
//  T1 XOR 32b: SrcA=32'h0000000A, SrcB=32'h00000005, op=0011 -> out_valid on the 5th edge after accept; Rd=32'h0000000F; illegal_op=0.
//  T2 Backpressure: AND 32'hFFFF00FF & 32'h0F0F0F0F, out_ready=0 for 10 cycles
//     -> Rd=32'h0F0F000F held stable; in_ready=0 throughout; in_valid pulses ignored.
//  T3 Illegal op 4'b1111, SrcA=SrcB=32'hFFFFFFFF -> Rd=0, illegal_op=1 (Zero=1 if enabled).
//  T4 Reset mid-RUN: accept OR after 2 RUN edges, pull reset low for 1 edge
//     -> out_valid=0, Rd=0, in_ready=1 next cycle; no stale response.
//  T5 Back-to-back: XNOR 8'hAA/8'h55 then XOR 8'h0A/8'h05 at DATA_WIDTH=8, CHUNK_WIDTH=8
//     -> Rd=8'h00 then 8'h0F; Zero=1 then 0 when enabled.
//  T6 DATA_WIDTH=1, CHUNK_WIDTH=1: XOR 1'b1 ^ 1'b0 -> Rd=1'b1 on the 2nd edge after accept.

Source files
------------

// File: rtl/logic_unit_serial_if.sv
// ============================================================================
// Module   : logic_unit_serial_if
// Purpose  : Request/response bundle between the execute stage and the serial
//            logic unit. Optional Zero output under LOGIC_UNIT_ZERO_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logic_unit_serial_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [OPCODE_LENGTH-1:0] Operation;
   logic [DATA_WIDTH-1:0]    SrcA;
   logic [DATA_WIDTH-1:0]    SrcB;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_WIDTH-1:0]    Rd;
   logic                     illegal_op;
   logic                     busy;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   logic                     Zero;
`endif

   modport master (
      output in_valid, Operation, SrcA, SrcB, out_ready,
      input  in_ready, out_valid, Rd, illegal_op, busy
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      , input Zero
`endif
   );

   modport slave (
      input  in_valid, Operation, SrcA, SrcB, out_ready,
      output in_ready, out_valid, Rd, illegal_op, busy
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      , output Zero
`endif
   );
endinterface

`default_nettype wire

// File: rtl/logic_unit_serial.sv
// ============================================================================
// Module   : logic_unit_serial
// Purpose  : Multi-cycle AND/OR/XOR/XNOR unit, CHUNK_WIDTH bits per cycle.
//            Optional Zero flag under LOGIC_UNIT_ZERO_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_serial #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int CHUNK_WIDTH   = 8
) (
   input  wire logic           clk,
   input  wire logic           reset,
   logic_unit_serial_if.slave  bus
);

   localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam logic [OPCODE_LENGTH-1:0] c_OP_AND  = OPCODE_LENGTH'(0);
   localparam logic [OPCODE_LENGTH-1:0] c_OP_OR   = OPCODE_LENGTH'(1);
   localparam logic [OPCODE_LENGTH-1:0] c_OP_XOR  = OPCODE_LENGTH'(3);
   localparam logic [OPCODE_LENGTH-1:0] c_OP_XNOR = OPCODE_LENGTH'(4);

   logic [1:0]               r_state;
   logic [1:0]               w_nextState;
   logic [DATA_WIDTH-1:0]    r_srcA;
   logic [DATA_WIDTH-1:0]    r_srcB;
   logic [OPCODE_LENGTH-1:0] r_op;
   logic [DATA_WIDTH-1:0]    r_rd;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_illegal;
   logic                     w_lastChunk;
   logic                     w_accept;
   logic [CHUNK_WIDTH-1:0]   w_res [N];
   logic [CHUNK_WIDTH-1:0]   w_curRes;

   // Unrecognised opcodes yield zero so an illegal request still returns Rd=0.
   function automatic logic [CHUNK_WIDTH-1:0] f_op(
      input logic [OPCODE_LENGTH-1:0] op,
      input logic [CHUNK_WIDTH-1:0]   a,
      input logic [CHUNK_WIDTH-1:0]   b
   );
      case (op)
         c_OP_AND:  f_op = a & b;
         c_OP_OR:   f_op = a | b;
         c_OP_XOR:  f_op = a ^ b;
         c_OP_XNOR: f_op = ~(a ^ b);
         default:   f_op = '0;
      endcase
   endfunction

   function automatic logic f_legal(input logic [OPCODE_LENGTH-1:0] op);
      f_legal = (op == c_OP_AND) || (op == c_OP_OR) ||
                (op == c_OP_XOR) || (op == c_OP_XNOR);
   endfunction

   for (genvar g = 0; g < N; g++) begin : g_chunk
      assign w_res[g] = f_op(r_op, r_srcA[g*CHUNK_WIDTH +: CHUNK_WIDTH],
                                   r_srcB[g*CHUNK_WIDTH +: CHUNK_WIDTH]);
   end

   always_comb begin
      w_curRes = '0;
      for (int i = 0; i < N; i++) begin
         if (r_cnt == CNT_W'(i)) w_curRes = w_res[i];
      end
   end

   assign w_lastChunk = (r_cnt == CNT_W'(N - 1));
   assign w_accept    = (r_state == c_IDLE) && bus.in_valid;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= c_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         c_IDLE:  if (bus.in_valid)  w_nextState = c_RUN;
         c_RUN:   if (w_lastChunk)   w_nextState = c_DONE;
         c_DONE:  if (bus.out_ready) w_nextState = c_IDLE;
         default: w_nextState = c_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready   = (r_state == c_IDLE);
      bus.out_valid  = (r_state == c_DONE);
      bus.busy       = (r_state != c_IDLE);
      bus.Rd         = r_rd;
      bus.illegal_op = r_illegal && (r_state == c_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_srcA    <= '0;
         r_srcB    <= '0;
         r_op      <= '0;
         r_rd      <= '0;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
      end else if (w_accept) begin
         r_srcA    <= bus.SrcA;
         r_srcB    <= bus.SrcB;
         r_op      <= bus.Operation;
         r_rd      <= '0;
         r_cnt     <= '0;
         r_illegal <= !f_legal(bus.Operation);
      end else if (r_state == c_RUN) begin
         for (int i = 0; i < N; i++) begin
            if (r_cnt == CNT_W'(i)) r_rd[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_curRes;
         end
         r_cnt <= r_cnt + 1'b1;
      end
   end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   logic r_nonzero;

   always_ff @(posedge clk) begin
      if (!reset)                  r_nonzero <= 1'b0;
      else if (w_accept)           r_nonzero <= 1'b0;
      else if (r_state == c_RUN)   r_nonzero <= r_nonzero | (|w_curRes);
   end

   assign bus.Zero = !r_nonzero && (r_state == c_DONE);
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_serial.sv
// ============================================================================
// Module   : tb_logic_unit_serial
// Purpose  : Directed scoreboard bench for three widths of logic_unit_serial.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_serial;

   typedef struct {
      logic [31:0] rd;
      logic        ill;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   nAsserts = 0;
   int   nFail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   logic_unit_serial_if #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) if32 ();
   logic_unit_serial_if #(.DATA_WIDTH(8),  .OPCODE_LENGTH(4)) if8 ();
   logic_unit_serial_if #(.DATA_WIDTH(1),  .OPCODE_LENGTH(4)) if1 ();

   logic_unit_serial #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .CHUNK_WIDTH(8))
      u32 (.clk(clk), .reset(reset), .bus(if32));
   logic_unit_serial #(.DATA_WIDTH(8), .OPCODE_LENGTH(4), .CHUNK_WIDTH(8))
      u8 (.clk(clk), .reset(reset), .bus(if8));
   logic_unit_serial #(.DATA_WIDTH(1), .OPCODE_LENGTH(4), .CHUNK_WIDTH(1))
      u1 (.clk(clk), .reset(reset), .bus(if1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int widthOf(input int sel);
      return (sel == 0) ? 32 : (sel == 1) ? 8 : 1;
   endfunction

   function automatic logic getInReady(input int sel);
      return (sel == 0) ? if32.in_ready : (sel == 1) ? if8.in_ready : if1.in_ready;
   endfunction
   function automatic logic getOutValid(input int sel);
      return (sel == 0) ? if32.out_valid : (sel == 1) ? if8.out_valid : if1.out_valid;
   endfunction
   function automatic logic getIllegal(input int sel);
      return (sel == 0) ? if32.illegal_op : (sel == 1) ? if8.illegal_op : if1.illegal_op;
   endfunction
   function automatic logic getBusy(input int sel);
      return (sel == 0) ? if32.busy : (sel == 1) ? if8.busy : if1.busy;
   endfunction
   function automatic logic [31:0] getRd(input int sel);
      return (sel == 0) ? if32.Rd : (sel == 1) ? {24'd0, if8.Rd} : {31'd0, if1.Rd};
   endfunction
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   function automatic logic getZero(input int sel);
      return (sel == 0) ? if32.Zero : (sel == 1) ? if8.Zero : if1.Zero;
   endfunction
`endif

   task automatic setReq(input int sel, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
      case (sel)
         0: begin if32.in_valid = v; if32.SrcA = a;       if32.SrcB = b;       if32.Operation = op; end
         1: begin if8.in_valid  = v; if8.SrcA  = a[7:0];  if8.SrcB  = b[7:0];  if8.Operation  = op; end
         default: begin if1.in_valid = v; if1.SrcA = a[0]; if1.SrcB = b[0]; if1.Operation = op; end
      endcase
   endtask

   task automatic setOutReady(input int sel, input logic v);
      case (sel)
         0: if32.out_ready = v;
         1: if8.out_ready = v;
         default: if1.out_ready = v;
      endcase
   endtask

   // Reference result over the full word; masked to the instance width.
   function automatic exp_t model(input int sel, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] op);
      exp_t e;
      logic [31:0] mask;
      int w;
      w = widthOf(sel);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      e.ill = 1'b0;
      case (op)
         4'b0000: e.rd = a & b;
         4'b0001: e.rd = a | b;
         4'b0011: e.rd = a ^ b;
         4'b0100: e.rd = ~(a ^ b);
         default: begin e.rd = 32'd0; e.ill = 1'b1; end
      endcase
      e.rd   = e.rd & mask;
      e.zero = (e.rd == 32'd0);
      return e;
   endfunction

   task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input int hold, input string tag);
      exp_t e;
      int   t;
      int   edges;
      int   n;
      logic [31:0] held;
      n = (widthOf(sel) == 32) ? 4 : 1;
      sb.push_back(model(sel, a, b, op));
      t = 0;
      while (!getInReady(sel) && t < 50) begin @(negedge clk); t++; end
      check({tag, " ready"}, 32'(getInReady(sel)), 32'd1);
      setReq(sel, 1'b1, a, b, op);
      edges = 0;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (edges == 1) setReq(sel, 1'b0, 32'd0, 32'd0, 4'd0);
      end while (!getOutValid(sel) && edges < 50);
      check({tag, " latency"}, 32'(edges), 32'(n + 1));
      e = sb.pop_front();
      check({tag, " rd"}, getRd(sel), e.rd);
      check({tag, " illegal"}, 32'(getIllegal(sel)), 32'(e.ill));
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      check({tag, " zero"}, 32'(getZero(sel)), 32'(e.zero));
`endif
      held = getRd(sel);
      for (int i = 0; i < hold; i++) begin
         setReq(sel, i[0], ~a, ~b, 4'b0001);
         @(negedge clk);
         check({tag, " bp rd"}, getRd(sel), held);
         check({tag, " bp in_ready"}, 32'(getInReady(sel)), 32'd0);
         check({tag, " bp valid"}, 32'(getOutValid(sel)), 32'd1);
         check({tag, " bp illegal"}, 32'(getIllegal(sel)), 32'(e.ill));
      end
      setReq(sel, 1'b0, 32'd0, 32'd0, 4'd0);
      setOutReady(sel, 1'b1);
      @(negedge clk);
      setOutReady(sel, 1'b0);
      check({tag, " drop valid"}, 32'(getOutValid(sel)), 32'd0);
      check({tag, " idle ready"}, 32'(getInReady(sel)), 32'd1);
      check({tag, " rd kept"}, getRd(sel), held);
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         setReq(s, 1'b0, 32'd0, 32'd0, 4'd0);
         setOutReady(s, 1'b0);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         check("reset valid", 32'(getOutValid(s)), 32'd0);
         check("reset rd", getRd(s), 32'd0);
         check("reset illegal", 32'(getIllegal(s)), 32'd0);
         check("reset busy", 32'(getBusy(s)), 32'd0);
         check("reset ready", 32'(getInReady(s)), 32'd1);
      end
      reset = 1'b1;
      @(negedge clk);

      issue(0, 32'h0000000A, 32'h00000005, 4'b0011, 0, "T1 xor");
      issue(0, 32'hFFFF00FF, 32'h0F0F0F0F, 4'b0000, 10, "T2 and bp");
      issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111, 2, "T3 illegal");
      issue(0, 32'h12345678, 32'h80000001, 4'b0001, 0, "or");
      issue(0, 32'hDEADBEEF, 32'h0F0F0F0F, 4'b0100, 1, "xnor");

      // Reset two RUN edges into an OR request.
      setReq(0, 1'b1, 32'hA5A5A5A5, 32'h00000000, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      setReq(0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("T4 busy before", 32'(getBusy(0)), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("T4 valid", 32'(getOutValid(0)), 32'd0);
      check("T4 rd", getRd(0), 32'd0);
      check("T4 ready", 32'(getInReady(0)), 32'd1);
      check("T4 busy", 32'(getBusy(0)), 32'd0);
      setOutReady(0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("T4 no stale", 32'(getOutValid(0)), 32'd0);
      end
      setOutReady(0, 1'b0);

      issue(1, 32'h000000AA, 32'h00000055, 4'b0100, 0, "T5 xnor");
      issue(1, 32'h0000000A, 32'h00000005, 4'b0011, 0, "T5 xor");
      issue(1, 32'h000000F0, 32'h0000003C, 4'b0000, 3, "w8 and");
      issue(2, 32'd1, 32'd0, 4'b0011, 0, "T6 xor");
      issue(2, 32'd1, 32'd1, 4'b0100, 0, "w1 xnor");
      issue(2, 32'd1, 32'd1, 4'b0111, 1, "w1 illegal");

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule

`default_nettype wire
